bus_arbiter4: RTL

Round-robin arbiter that shares the processor's single tristate data bus among four requesters (CPU core, DMA, I/O port, debug). It drives the one-hot tristate enables and the 2-bit select of the 4:1 read-back multiplexer, and inserts a bus-turnaround gap between owners. Each grant is held while the owner keeps requesting, with a hold limit that forces a handoff when others are waiting.

---
 rtl/upx_defs.sv | 23 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/bus_arbiter4.sv | 105 ++++++++++
 3 files changed

// File: rtl/upx_defs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  upx_defs : shared state encodings, requester indices and helpers
//  Rev 1.0  : initial release
// ============================================================================
package upx_defs;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_TURN  = 2'b10;

    localparam logic [1:0] REQ_CPU = 2'd0;
    localparam logic [1:0] REQ_DMA = 2'd1;
    localparam logic [1:0] REQ_IO  = 2'd2;
    localparam logic [1:0] REQ_DBG = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  rr_pick4 : combinational round-robin picker, searches upward from ptr+1
//  Rev 1.0  : initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] w_idx;

    // Walk from lowest to highest priority so the last hit (ptr+1) wins.
    always_comb begin
        win   = ptr;
        any   = 1'b0;
        w_idx = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            w_idx = ptr + k[1:0];
            if (req[w_idx]) begin
                win = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  bus_arbiter4 : round-robin tristate bus arbiter with turnaround and hold limit
//  Rev 1.0      : initial release
// ============================================================================
module bus_arbiter4
    import upx_defs::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_en,
    output logic       busy
);

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
    localparam logic [7:0] c_hold_max  = 8'(MAX_HOLD);
    localparam logic [1:0] c_turn_last = 2'(TURN_CYC - 1);

    logic [1:0] r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_turn_cnt;
    logic [7:0] r_hold_cnt;

    logic [1:0] w_win;
    logic       w_any;
    logic       w_own_req;
    logic       w_others;
    logic       w_release;
    logic       w_arb;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .win (w_win),
        .any (w_any)
    );

    // gnt is one-hot at the owner while in GRANT, so it masks the owner out.
    // A saturated hold count still counts as having reached the limit.
    assign w_own_req = req[sel];
    assign w_others  = |(req & ~gnt);
    assign w_release = !w_own_req || ((r_hold_cnt >= c_hold_last) && w_others);
    assign w_arb     = (r_state == ST_IDLE) ||
                       ((r_state == ST_TURN) && (r_turn_cnt == c_turn_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= REQ_DBG;
            r_turn_cnt <= 2'd0;
            r_hold_cnt <= 8'd0;
            gnt        <= 4'b0000;
            sel        <= 2'b00;
            bus_en     <= 1'b0;
            busy       <= 1'b0;
        end else if (w_arb && w_any) begin
            r_state    <= ST_GRANT;
            r_ptr      <= w_win;
            r_hold_cnt <= 8'd0;
            gnt        <= onehot4(w_win);
            sel        <= w_win;
            bus_en     <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (r_state)
                ST_GRANT: begin
                    if (w_release) begin
                        r_state    <= ST_TURN;
                        r_turn_cnt <= 2'd0;
                        gnt        <= 4'b0000;
                        bus_en     <= 1'b0;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                ST_TURN: begin
                    if (r_turn_cnt == c_turn_last) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + 2'd1;
                    end
                end
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    gnt     <= 4'b0000;
                    bus_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
